// File: rtl/csa_serial_add_ctrl.sv
// Serial adder: one shared SLICE_W-bit carry-select slice sequenced over WIDTH/SLICE_W cycles.
// Optional signed-overflow output enabled by defining OVF_DETECT_EN.
module csa_serial_add_ctrl #(
   parameter int WIDTH   = 16,
   parameter int SLICE_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef OVF_DETECT_EN
   ,
   output logic             ovf
`endif
);

   localparam int N  = WIDTH / SLICE_W;
   localparam int IW = $clog2(N + 1);

   generate
      if (SLICE_W < 1 || WIDTH < SLICE_W || (WIDTH % SLICE_W) != 0) begin : g_param_chk
         $error("csa_serial_add_ctrl: WIDTH must be a non-zero multiple of SLICE_W");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t            state, state_nxt;
   logic [WIDTH-1:0]  wa, wb, ws, ws_nxt;
   logic              carry;
   logic [IW-1:0]     idx;
   logic              last;
   logic [31:0]       base;
   logic [SLICE_W-1:0] as, bs;
   logic [SLICE_W:0]  s0, s1, sel;

   assign last = (idx == IW'(N - 1));

   // Both slice results are formed up front; the registered carry only picks one.
   always_comb begin
      base   = 32'(idx) * 32'(SLICE_W);
      as     = wa[base +: SLICE_W];
      bs     = wb[base +: SLICE_W];
      s0     = {1'b0, as} + {1'b0, bs};
      s1     = {1'b0, as} + {1'b0, bs} + {{SLICE_W{1'b0}}, 1'b1};
      sel    = carry ? s1 : s0;
      ws_nxt = ws;
      ws_nxt[base +: SLICE_W] = sel[SLICE_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: if (start) state_nxt = RUN;
         RUN: begin
            busy = 1'b1;
            if (last) state_nxt = DONE;
         end
         DONE: begin
            busy      = 1'b1;
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wa    <= '0;
         wb    <= '0;
         ws    <= '0;
         carry <= 1'b0;
         idx   <= '0;
         sum   <= '0;
         cout  <= 1'b0;
`ifdef OVF_DETECT_EN
         ovf   <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  wa    <= a;
                  wb    <= b;
                  carry <= cin;
                  idx   <= '0;
               end
            end
            RUN: begin
               ws    <= ws_nxt;
               carry <= sel[SLICE_W];
               // Index returns to zero on the last slice so it never leaves 0..N-1.
               idx   <= last ? '0 : idx + 1'b1;
               if (last) begin
                  sum  <= ws_nxt;
                  cout <= sel[SLICE_W];
`ifdef OVF_DETECT_EN
                  ovf  <= wa[WIDTH-1] ^ wb[WIDTH-1] ^ ws_nxt[WIDTH-1] ^ sel[SLICE_W];
`endif
               end
            end
            default: ;
         endcase
      end
   end

endmodule
